prach_avst_packetizer: RTL and testbench
========================================

Name: prach_avst_packetizer

Overview:
- Transmit end of the PRACH Avalon-ST source interface toward the eth/xRAN framer.
- Takes the serial 16-bit I/Q stream out of the PRACH FFT stage (dr/di/dv plus sync).
- Packs 4 samples per 128-bit beat and frames each PKT_SAMPLES block as one packet, with sop/eop and a 16-bit channel tag.
- Absorbs sink backpressure in an internal beat FIFO; admission control drops whole packets rather than breaking framing.

Parameters:
- PKT_SAMPLES, 864: samples per packet; must be a multiple of 4. BEATS = PKT_SAMPLES/4 = 216.
- NUM_CHN, 24: packets per sync frame (8 antennas x 3 carriers); channel tag runs 0..NUM_CHN-1.
- FIFO_DEPTH, 512: beat FIFO depth in beats; power of 2 and >= BEATS+1.

Ports:
- clk  in  1  DSP clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- din_dr  in  16  FFT output sample, real part.
- din_di  in  16  FFT output sample, imaginary part.
- din_dv  in  1  sample valid.
- sync_in  in  1  qualifies the first sample of channel 0; only meaningful when din_dv=1.
- avst_source_data  out  128  packed beat.
- avst_source_valid  out  1  beat valid.
- avst_source_channel  out  16  packet channel tag, constant across a packet.
- avst_source_startofpacket  out  1  first beat of a packet.
- avst_source_endofpacket  out  1  last beat of a packet.
- avst_source_ready  in  1  sink ready; readyLatency 0.
- stat_clr  in  1  clears the sticky status bits.
- stat_overflow  out  1  sticky: a packet was dropped at admission.
- stat_sync_err  out  1  sticky: sync_in arrived mid-packet.

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in IDLE; counters 0.
- Beat packing:
  - Sample k (k=0 is first in time) maps to data[32k+15:32k]=dr and data[32k+31:32k+16]=di.
  - A beat is written to the FIFO in the cycle after its 4th sample.
  - FIFO entry = {channel[15:0], sop, eop, data[127:0]}.
- FSM states IDLE, RUN, DROP:
  - IDLE: samples are discarded. din_dv&sync_in -> admission check with chn=0.
  - Admission check, done at every packet's first sample: FIFO free space >= BEATS+1 -> RUN; otherwise -> DROP and set stat_overflow.
  - RUN: count samples 0..PKT_SAMPLES-1. Beat 0 carries sop=1; beat BEATS-1 carries eop=1.
  - After the last sample: chn+1; if chn was NUM_CHN-1 -> IDLE, else the next sample is the next packet's first (admission check).
  - DROP: count and discard a full packet, then advance chn exactly as in RUN.
  - din_dv=0 gaps are allowed anywhere and hold all state.
- sync_in at a packet boundary (sample count 0) in RUN or DROP: chn resets to 0. Not an error.
- sync_in mid-packet (sample count !=0):
  - Set stat_sync_err.
  - In RUN, in that same cycle, write a flush beat: already-packed samples, remaining lanes zero, eop=1. No full-beat write can collide in that cycle.
  - In DROP, write nothing.
  - Then restart as the first sample of chn=0 (admission check). The sync sample becomes lane 0 of the new packet.
- Free-space reservation: free space is decremented by BEATS+1 at admission and credited per unused reservation slot at eop. Reads only increase space, so mid-packet overflow is impossible.
- Output:
  - FIFO is show-ahead. Output registers load when (!valid | ready) and the FIFO is non-empty.
  - While valid&!ready, data/channel/sop/eop are held stable.
  - Latency: 4th sample at cycle N -> avst_source_valid at N+2 when the FIFO is empty and ready=1.
  - Full throughput: 1 beat per clk with ready=1.
- Status:
  - stat_clr has priority over a same-cycle set; the set is lost.
  - Status bits are not cleared by sync_in.
- Reset mid-packet: the FIFO and the output beat are abandoned; valid deasserts asynchronously.

Test Plan:
- Single sync, 24x864 contiguous samples, ready=1 -> 24 packets of 216 beats. Channels 0..23. sop on beat 0, eop on beat 215. Lane packing matches a ramp (dr=n, di=~n). First valid 2 clk after 4th sample. No status bits.
- Random din_dv gaps (50%) plus ready toggling (30% low) -> identical beat stream to scenario 1. Data/sop/eop/channel held stable during every ready=0 cycle.
- ready=0 for 2000 clk during frame -> packets 0,1 fit (434 slots <= 512); packet 2 dropped, stat_overflow=1. After ready returns, channel sequence 0,1,3,4... with no malformed packet.
- sync_in at sample 6 of chn 5 -> flush beat 1 = {s4,s5,0,0} with eop=1, stat_sync_err=1. New packet chn=0 starts with the sync sample in lane 0.
- Samples before first sync, and after chn 23 completes -> no output beats. Next sync restarts at chn 0.
- rst_n low mid-packet with valid=1 -> all outputs 0 immediately. After release, a clean frame repeats scenario 1 exactly.

Source files
------------

// File: rtl/prach_avst_packetizer.sv
// PRACH Avalon-ST packetizer: packs 4 I/Q samples per 128-bit beat and
// frames PKT_SAMPLES samples per packet, buffered in a beat FIFO.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   din_dr/din_di/din_dv     FFT sample stream (real, imag, valid)
//   sync_in                  first sample of channel 0 (with din_dv)
//   avst_source_*            Avalon-ST source (data/valid/channel/sop/eop,
//                            ready with readyLatency 0)
//   stat_clr                 clears sticky status
//   stat_overflow            packet dropped at admission
//   stat_sync_err            sync seen mid-packet
module prach_avst_packetizer #(
   parameter int PKT_SAMPLES = 864,
   parameter int NUM_CHN     = 24,
   parameter int FIFO_DEPTH  = 512
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [15:0]  din_dr,
   input  logic [15:0]  din_di,
   input  logic         din_dv,
   input  logic         sync_in,
   output logic [127:0] avst_source_data,
   output logic         avst_source_valid,
   output logic [15:0]  avst_source_channel,
   output logic         avst_source_startofpacket,
   output logic         avst_source_endofpacket,
   input  logic         avst_source_ready,
   input  logic         stat_clr,
   output logic         stat_overflow,
   output logic         stat_sync_err
);

   localparam int BEATS = PKT_SAMPLES / 4;
   localparam int SW    = $clog2(PKT_SAMPLES);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int FW    = AW + 1;
   localparam int EW    = 146;

   typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

   state_t         st, st_n, pst;
   logic [SW-1:0]  scnt, scnt_n, pos;
   logic [15:0]    chn, chn_n, cchn;
   logic [95:0]    lanes, lanes_n;
   logic           wr_vld, wr_vld_n;
   logic [EW-1:0]  wr_ent, wr_ent_n;
   logic [FW-1:0]  free, free_n, credit, resv;
   logic [FW-1:0]  wptr, rptr;
   logic           out_vld, rd;
   logic [EW-1:0]  out_ent;
   logic           ovf, serr, ovf_set, err_set;
   logic           first, mid_sync, admit;
   logic [31:0]    smp;

   logic [EW-1:0]  mem [FIFO_DEPTH];

   assign rd = (!out_vld | avst_source_ready) & (wptr != rptr);

   always_comb begin
      st_n     = st;
      scnt_n   = scnt;
      chn_n    = chn;
      lanes_n  = lanes;
      wr_vld_n = 1'b0;
      wr_ent_n = wr_ent;
      ovf_set  = 1'b0;
      err_set  = 1'b0;
      credit   = '0;
      resv     = '0;
      first    = 1'b0;
      mid_sync = 1'b0;
      admit    = 1'b0;
      pst      = st;
      pos      = scnt;
      cchn     = chn;
      smp      = {din_di, din_dr};
      if (din_dv) begin
         if (st == IDLE) first = sync_in;
         else            first = sync_in | (scnt == '0);
         mid_sync = (st != IDLE) & sync_in & (scnt != '0);
         if (sync_in) cchn = '0;
         // Close the interrupted packet; its beat stage is free this
         // cycle because the sync sample starts a new beat.
         if (mid_sync) begin
            err_set = 1'b1;
            if (st == RUN) begin
               wr_vld_n = 1'b1;
               wr_ent_n = {chn, scnt < SW'(4), 1'b1, 32'h0, lanes};
               credit   = FW'(BEATS) - FW'(scnt >> 2);
            end
         end
         if (first) begin
            pos   = '0;
            admit = free >= FW'(BEATS + 1);
            pst   = admit ? RUN : DROP;
            if (admit) resv = FW'(BEATS + 1);
            else       ovf_set = 1'b1;
         end
         if (pst != IDLE) begin
            if (pst == RUN) begin
               unique case (pos[1:0])
                  2'd0: lanes_n = {64'h0, smp};
                  2'd1: lanes_n[63:32] = smp;
                  2'd2: lanes_n[95:64] = smp;
                  2'd3: begin
                     wr_vld_n = 1'b1;
                     wr_ent_n = {cchn, pos < SW'(4),
                                 pos == SW'(PKT_SAMPLES - 1),
                                 smp, lanes};
                     lanes_n  = '0;
                  end
               endcase
            end
            st_n = pst;
            if (pos == SW'(PKT_SAMPLES - 1)) begin
               scnt_n = '0;
               if (pst == RUN) credit = FW'(1);
               if (cchn == 16'(NUM_CHN - 1)) begin
                  st_n  = IDLE;
                  chn_n = '0;
               end else begin
                  chn_n = cchn + 16'd1;
               end
            end else begin
               scnt_n = pos + SW'(1);
               chn_n  = cchn;
            end
         end
      end
      free_n = free - resv + credit + FW'(rd);
   end

   always_ff @(posedge clk) begin
      if (wr_vld) mem[wptr[AW-1:0]] <= wr_ent;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= IDLE;
         scnt    <= '0;
         chn     <= '0;
         lanes   <= '0;
         wr_vld  <= 1'b0;
         wr_ent  <= '0;
         free    <= FW'(FIFO_DEPTH);
         wptr    <= '0;
         rptr    <= '0;
         out_vld <= 1'b0;
         out_ent <= '0;
         ovf     <= 1'b0;
         serr    <= 1'b0;
      end else begin
         st     <= st_n;
         scnt   <= scnt_n;
         chn    <= chn_n;
         lanes  <= lanes_n;
         wr_vld <= wr_vld_n;
         wr_ent <= wr_ent_n;
         free   <= free_n;
         wptr   <= wptr + FW'(wr_vld);
         rptr   <= rptr + FW'(rd);
         if (rd) begin
            out_vld <= 1'b1;
            out_ent <= mem[rptr[AW-1:0]];
         end else if (avst_source_ready) begin
            out_vld <= 1'b0;
         end
         ovf  <= stat_clr ? 1'b0 : (ovf | ovf_set);
         serr <= stat_clr ? 1'b0 : (serr | err_set);
      end
   end

   assign avst_source_valid         = out_vld;
   assign avst_source_data          = out_ent[127:0];
   assign avst_source_endofpacket   = out_ent[128];
   assign avst_source_startofpacket = out_ent[129];
   assign avst_source_channel       = out_ent[145:130];
   assign stat_overflow             = ovf;
   assign stat_sync_err             = serr;

endmodule

// File: tb/tb_prach_avst_packetizer.sv
// Randomized bench for prach_avst_packetizer with a packet-level model.
// Expected beats are built from the sample stream and matched in order.
module tb_prach_avst_packetizer;

   localparam int PKT = 864;
   localparam int NCH = 24;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [15:0]  din_dr = '0, din_di = '0;
   logic         din_dv = 1'b0, sync_in = 1'b0;
   logic [127:0] data;
   logic         valid, sop, eop;
   logic [15:0]  ch;
   logic         ready = 1'b0, stat_clr = 1'b0;
   logic         ovf, serr;

   prach_avst_packetizer dut (
      .clk(clk), .rst_n(rst_n),
      .din_dr(din_dr), .din_di(din_di),
      .din_dv(din_dv), .sync_in(sync_in),
      .avst_source_data(data),
      .avst_source_valid(valid),
      .avst_source_channel(ch),
      .avst_source_startofpacket(sop),
      .avst_source_endofpacket(eop),
      .avst_source_ready(ready),
      .stat_clr(stat_clr),
      .stat_overflow(ovf),
      .stat_sync_err(serr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] dr;
      logic [15:0] di;
      bit          sync;
      bit          clr;
   } smp_t;

   smp_t         sq[$];
   logic [145:0] exp_q[$];
   int           n_chk = 0, n_err = 0;
   int           rn = 0;

   // model state
   bit           m_act, m_drop, e_ovf, e_err;
   int           m_chn, m_cnt, m_ord, drop_at = -1;
   logic [31:0]  m_pk[$];

   task automatic chk(input string tag,
                      input logic [159:0] got,
                      input logic [159:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void emit(bit flush);
      int sz = m_pk.size();
      int nb = flush ? sz / 4 + 1 : sz / 4;
      logic [127:0] d;
      for (int b = 0; b < nb; b++) begin
         d = '0;
         for (int l = 0; l < 4; l++)
            if (4 * b + l < sz) d[32*l +: 32] = m_pk[4*b+l];
         exp_q.push_back({m_chn[15:0], b == 0, b == nb - 1, d});
      end
   endfunction

   function automatic void start(int c);
      m_chn  = c;
      m_cnt  = 0;
      m_pk.delete();
      m_drop = (m_ord == drop_at);
      m_ord++;
      m_act  = 1'b1;
      if (m_drop) e_ovf = 1'b1;
   endfunction

   function automatic void model();
      m_ord = 0;
      foreach (sq[i]) begin
         if (!m_act) begin
            if (sq[i].sync) start(0);
         end else if (sq[i].sync) begin
            if (m_cnt > 0) begin
               e_err = 1'b1;
               if (!m_drop) emit(1'b1);
            end
            start(0);
         end else if (m_cnt == 0) begin
            start(m_chn + 1);
         end
         if (m_act) begin
            m_pk.push_back({sq[i].di, sq[i].dr});
            m_cnt++;
            if (m_cnt == PKT) begin
               if (!m_drop) emit(1'b0);
               if (m_chn == NCH - 1) m_act = 1'b0;
               m_cnt = 0;
            end
         end
         if (sq[i].clr) begin
            e_ovf = 1'b0;
            e_err = 1'b0;
         end
      end
   endfunction

   function automatic void add_ramp(int cnt, bit sf, bit cf);
      smp_t s;
      for (int i = 0; i < cnt; i++) begin
         s.dr   = rn[15:0];
         s.di   = ~rn[15:0];
         s.sync = (i == 0) && sf;
         s.clr  = (i == 0) && cf;
         sq.push_back(s);
         rn++;
      end
   endfunction

   task automatic drive(bit dv, smp_t s, bit rdy);
      din_dv   = dv;
      din_dr   = s.dr;
      din_di   = s.di;
      sync_in  = s.sync;
      stat_clr = dv & s.clr;
      ready    = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic run(int low, int gap, int stall, bit lat);
      int   sc = 0;
      smp_t j;
      bit   r;
      foreach (sq[i]) begin
         while ($urandom_range(99) < gap) begin
            j.dr   = 16'($urandom);
            j.di   = 16'($urandom);
            j.sync = 1'($urandom_range(1));
            j.clr  = 1'b0;
            r = (sc >= stall) && ($urandom_range(99) >= low);
            drive(1'b0, j, r);
            sc++;
         end
         r = (sc >= stall) && ($urandom_range(99) >= low);
         drive(1'b1, sq[i], r);
         sc++;
         if (lat && i >= 3 && i <= 5) chk("latency", valid, i == 5);
      end
   endtask

   task automatic drain();
      smp_t j = '{default: '0};
      int   k = 0;
      while (exp_q.size() != 0 && k < 4000) begin
         drive(1'b0, j, 1'b1);
         k++;
      end
      chk("drain", exp_q.size(), 0);
      repeat (10) drive(1'b0, j, 1'b1);
   endtask

   task automatic chk_stat(string tag);
      chk({tag, "_ovf"}, ovf, e_ovf);
      chk({tag, "_serr"}, serr, e_err);
   endtask

   task automatic clear_stat();
      stat_clr = 1'b1;
      @(posedge clk);
      #1;
      stat_clr = 1'b0;
      e_ovf = 1'b0;
      e_err = 1'b0;
   endtask

   task automatic model_reset();
      m_act = 1'b0;
      m_cnt = 0;
      m_chn = 0;
      e_ovf = 1'b0;
      e_err = 1'b0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      din_dv = 1'b0;
      ready  = 1'b0;
      rst_n  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset", {valid, sop, eop, ch, data, ovf, serr}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // sink side: in-order beat check and hold-stability check
   logic         hold = 1'b0;
   logic [145:0] hold_ent = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (hold)
            chk("hold", {valid, ch, sop, eop, data}, {1'b1, hold_ent});
         if (valid && ready) begin
            if (exp_q.size() == 0) chk("extra", valid, 0);
            else chk("beat", {ch, sop, eop, data}, exp_q.pop_front());
         end
         hold     <= valid && !ready;
         hold_ent <= {ch, sop, eop, data};
      end else begin
         hold <= 1'b0;
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      smp_t j;
      int   p;
      do_reset();

      // samples before any sync are discarded
      sq.delete();
      for (int i = 0; i < 40; i++) begin
         j.dr = 16'($urandom); j.di = 16'($urandom);
         j.sync = 1'b0; j.clr = 1'b0;
         sq.push_back(j);
      end
      model(); run(0, 0, 0, 0); drain();

      // full frame, contiguous, then trailing samples after chn 23
      sq.delete();
      add_ramp(NCH * PKT, 1'b1, 1'b0);
      add_ramp(50, 1'b0, 1'b0);
      model(); run(0, 0, 0, 1); drain(); chk_stat("frame");

      // dv gaps and ready toggling
      sq.delete();
      add_ramp(6 * PKT, 1'b1, 1'b0);
      model(); run(30, 50, 0, 0); drain(); chk_stat("gaps");

      // long sink stall: packet 2 of the frame is dropped
      drop_at = 2;
      sq.delete();
      add_ramp(5 * PKT, 1'b1, 1'b0);
      model(); run(0, 0, 2000, 0); drain(); chk_stat("stall");
      drop_at = -1;
      clear_stat(); chk_stat("clr");

      // sync at sample 6 of chn 5 forces a flush beat
      sq.delete();
      add_ramp(5 * PKT + 6, 1'b1, 1'b0);
      add_ramp(2 * PKT, 1'b1, 1'b0);
      model(); run(0, 0, 0, 0); drain(); chk_stat("sync");
      clear_stat();

      // random mid-packet sync with a same-cycle clear
      p = int'($urandom_range(PKT - 1, 1));
      sq.delete();
      add_ramp(p, 1'b0, 1'b0);
      add_ramp(PKT, 1'b1, 1'b1);
      model(); run(20, 20, 0, 0); drain(); chk_stat("syncclr");

      // reset while a beat is presented
      sq.delete();
      add_ramp(41, 1'b1, 1'b0);
      run(100, 0, 0, 0);
      chk("pre_rst_valid", valid, 1);
      din_dv = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst", {valid, sop, eop, ch, data, ovf, serr}, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      sq.delete();
      add_ramp(NCH * PKT, 1'b1, 1'b0);
      model(); run(0, 0, 0, 1); drain(); chk_stat("again");

      $display("== %0d vectors applied, %0d miscompares ==",
               n_chk, n_err);
      $finish;
   end

endmodule
